// File: rtl/matmul_8x8_c_writer.sv
// Collects one 8x8 fp16 result as NUM_BEATS column beats and writes each
// column to the two C memory halves at consecutive addresses. The writer
// is armed by start_write and returns to idle after the final column.
module matmul_8x8_c_writer #(
    parameter int DWIDTH          = 16,
    parameter int BB_MAT_MUL_SIZE = 4,
    parameter int AWIDTH          = 7,
    parameter int NUM_BEATS       = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start_write,
    input  logic [AWIDTH-1:0]                   c_base_addr,
    input  logic                                c_valid,
    input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0]   c_data_row_0,
    input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0]   c_data_row_1,
    output logic [AWIDTH-1:0]                   c_addr,
    output logic                                c_we,
    output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0]   c_data_0,
    output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0]   c_data_1,
    output logic                                busy,
    output logic                                done_write,
    output logic                                overflow
);

    localparam int CNT_W = $clog2(NUM_BEATS) + 1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [AWIDTH-1:0]  base_q;
    logic [CNT_W-1:0]   beat_cnt;
    logic               arm;
    logic               accept;
    logic               last_beat;

    // A start only arms from IDLE; beats are only taken while collecting.
    assign arm       = (state == IDLE) && start_write;
    assign accept    = (state == COLLECT) && c_valid;
    assign last_beat = (beat_cnt == CNT_W'(NUM_BEATS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the state-decoded status outputs.
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done_write = 1'b0;
        case (state)
            IDLE: begin
                if (start_write) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                busy = 1'b1;
                if (accept && last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_write = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latched base address and beat counter; the counter holds at the last
    // index rather than running past it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            base_q   <= '0;
            beat_cnt <= '0;
        end else if (arm) begin
            base_q   <= c_base_addr;
            beat_cnt <= '0;
        end else if (accept && !last_beat) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

    // Write port: one registered write per accepted beat; address and data
    // hold their last value between writes. Address wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            c_we     <= 1'b0;
            c_addr   <= '0;
            c_data_0 <= '0;
            c_data_1 <= '0;
        end else begin
            c_we <= accept;
            if (accept) begin
                c_addr   <= base_q + AWIDTH'(beat_cnt);
                c_data_0 <= c_data_row_0;
                c_data_1 <= c_data_row_1;
            end
        end
    end

    // Sticky flag for any beat presented while the writer is not collecting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (c_valid && (state != COLLECT)) begin
            overflow <= 1'b1;
        end
    end

endmodule
